data_memory_arbiter: RTL and testbench

//  Shares the single-port 16x4 data memory between the CPU control unit and an I/O requester.

---
 rtl/data_memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Arbiter sharing the single-port 16x4 data memory between the CPU and an I/O requester.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed CPU priority otherwise.
module data_memory_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a requester holds req with we/addr/wdata stable until its 1-cycle ack.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic                r_txn_we, w_txn_we_nxt;
    logic                r_owner, w_owner_nxt;
    logic                r_cpu_ack, w_cpu_ack_nxt;
    logic                r_io_ack, w_io_ack_nxt;
    logic [DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DATA_W-1:0]   r_io_rdata, w_io_rdata_nxt;

    // A req still high in its own ack cycle belongs to the finished transaction.
    logic w_cpu_elig, w_io_elig, w_grant_io;
    assign w_cpu_elig = cpu_req & ~r_cpu_ack;
    assign w_io_elig  = io_req & ~r_io_ack;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_grant_io = w_io_elig & (~w_cpu_elig | ~r_owner);
`else
    assign w_grant_io = w_io_elig & ~w_cpu_elig;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_txn_we_nxt    = r_txn_we;
        w_owner_nxt     = r_owner;
        w_cpu_ack_nxt   = 1'b0;
        w_io_ack_nxt    = 1'b0;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_io_rdata_nxt  = r_io_rdata;
        case (r_state)
            S_IDLE: begin
                w_mem_we_nxt = 1'b0;
                if (w_cpu_elig || w_io_elig) begin
                    w_state_nxt     = S_ACCESS;
                    w_owner_nxt     = w_grant_io;
                    w_mem_we_nxt    = w_grant_io ? io_we    : cpu_we;
                    w_txn_we_nxt    = w_grant_io ? io_we    : cpu_we;
                    w_mem_addr_nxt  = w_grant_io ? io_addr  : cpu_addr;
                    w_mem_wdata_nxt = w_grant_io ? io_wdata : cpu_wdata;
                end
            end
            S_ACCESS: begin
                w_mem_we_nxt = 1'b0;
                w_state_nxt  = S_RESP;
            end
            S_RESP: begin
                w_mem_we_nxt = 1'b0;
                if (!r_txn_we) begin
                    if (r_owner) w_io_rdata_nxt  = mem_rdata;
                    else         w_cpu_rdata_nxt = mem_rdata;
                end
                w_cpu_ack_nxt = ~r_owner;
                w_io_ack_nxt  = r_owner;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_txn_we    <= 1'b0;
            r_owner     <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_io_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_io_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_txn_we    <= w_txn_we_nxt;
            r_owner     <= w_owner_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_io_ack    <= w_io_ack_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_io_rdata  <= w_io_rdata_nxt;
        end
    end

    assign cpu_ack     = r_cpu_ack;
    assign io_ack      = r_io_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign io_rdata    = r_io_rdata;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign owner       = r_owner;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter with a behavioural 16x4 synchronous-read memory.
module tb_data_memory_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0] cpu_addr = '0, cpu_wdata = '0;
  logic       io_req = 1'b0, io_we = 1'b0;
  logic [3:0] io_addr = '0, io_wdata = '0;
  logic       cpu_ack, io_ack, mem_we, busy, owner;
  logic [3:0] cpu_rdata, io_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_rdata;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_cpu_q[$];
  logic [3:0] exp_io_q[$];
  logic       grant_log[$];
  logic [3:0] ref_mem[16];
  logic [3:0] exp_rd[2];
  logic [3:0] mem[16];
  logic       prev_busy = 1'b0, prev_cpu_ack = 1'b0, prev_io_ack = 1'b0;

  data_memory_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard / protocol monitor
  always @(negedge clk) begin
    check_eq("ack_excl", 32'(cpu_ack & io_ack), 0);
    check_eq("cpu_ack_width", 32'(cpu_ack & prev_cpu_ack), 0);
    check_eq("io_ack_width", 32'(io_ack & prev_io_ack), 0);
    if (cpu_ack) begin
      if (exp_cpu_q.size() == 0) check_eq("cpu_ack_unexp", 32'(cpu_ack), 0);
      else check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_q.pop_front()));
    end
    if (io_ack) begin
      if (exp_io_q.size() == 0) check_eq("io_ack_unexp", 32'(io_ack), 0);
      else check_eq("io_rdata", 32'(io_rdata), 32'(exp_io_q.pop_front()));
    end
    if (busy && !prev_busy) grant_log.push_back(owner);
    prev_busy    = busy;
    prev_cpu_ack = cpu_ack;
    prev_io_ack  = io_ack;
  end

  task automatic push_exp(input bit is_io, input bit we, input logic [3:0] addr,
                          input logic [3:0] wdata);
    if (we) ref_mem[addr] = wdata;
    else exp_rd[is_io] = ref_mem[addr];
    if (is_io) exp_io_q.push_back(exp_rd[1]);
    else exp_cpu_q.push_back(exp_rd[0]);
  endtask

  // driver: one transaction, checking the ACCESS/RESP cycles and the ack latency
  task automatic txn(input bit is_io, input bit we, input logic [3:0] addr,
                     input logic [3:0] wdata, input int exp_lat);
    int  n;
    bit  seen;
    @(negedge clk);
    if (is_io) begin
      io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    push_exp(is_io, we, addr, wdata);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == exp_lat - 2) begin
        check_eq("acc_busy", 32'(busy), 1);
        check_eq("acc_owner", 32'(owner), 32'(is_io));
        check_eq("acc_mem_we", 32'(mem_we), 32'(we));
        check_eq("acc_mem_addr", 32'(mem_addr), 32'(addr));
        if (we) check_eq("acc_mem_wdata", 32'(mem_wdata), 32'(wdata));
      end
      if (n == exp_lat - 1) check_eq("resp_mem_we", 32'(mem_we), 0);
      seen = is_io ? io_ack : cpu_ack;
    end
    check_eq(is_io ? "io_latency" : "cpu_latency", 32'(n), 32'(exp_lat));
    if (is_io) io_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
    check_eq({tag, "_io_ack"}, 32'(io_ack), 0);
    check_eq({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
    check_eq({tag, "_io_rdata"}, 32'(io_rdata), 0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_owner"}, 32'(owner), 0);
    check_eq({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  initial begin
    int acks;
    int n;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // reset held for 2 cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset");

    // CPU write then read back
    txn(1'b0, 1'b1, 4'd3, 4'hA, 3);
    txn(1'b0, 1'b0, 4'd3, 4'h0, 3);

    // preload through both requesters, leaving I/O as last owner
    txn(1'b0, 1'b1, 4'd1, 4'h5, 3);
    txn(1'b1, 1'b1, 4'd2, 4'hC, 3);

    // simultaneous reads: CPU first under either policy here
    fork
      txn(1'b0, 1'b0, 4'd1, 4'h0, 3);
      txn(1'b1, 1'b0, 4'd2, 4'h0, 6);
    join

    // CPU-only transaction, then a tie decided by policy
    txn(1'b0, 1'b0, 4'd3, 4'h0, 3);
    fork
      txn(1'b0, 1'b0, 4'd1, 4'h0, RR ? 6 : 3);
      txn(1'b1, 1'b0, 4'd3, 4'h0, RR ? 3 : 6);
    join

    // both requests held continuously: grants must alternate
    @(negedge clk);
    grant_log.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd1;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 4'd2;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 4'd1, 4'h0);
      push_exp(1'b1, 1'b0, 4'd2, 4'h0);
    end
    acks = 0;
    n = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ack || io_ack) acks++;
    end
    cpu_req = 1'b0;
    io_req  = 1'b0;
    check_eq("held_ack_count", 32'(acks), 4);
    check_eq("held_grant_count", 32'(grant_log.size()), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check_eq($sformatf("held_grant%0d", i), 32'(grant_log[i]), 32'((i % 2) ^ int'(RR)));

    // writes leave rdata untouched; top address boundary
    txn(1'b1, 1'b1, 4'd5, 4'h7, 3);
    txn(1'b0, 1'b1, 4'hF, 4'hF, 3);
    txn(1'b0, 1'b0, 4'hF, 4'h0, 3);
    txn(1'b1, 1'b0, 4'd5, 4'h0, 3);
    txn(1'b1, 1'b1, 4'd0, 4'h6, 3);
    txn(1'b0, 1'b0, 4'd0, 4'h0, 3);

    // reset during RESP of a CPU read: no ack, back to IDLE
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    @(negedge clk);
    check_eq("abort_access_busy", 32'(busy), 1);
    @(negedge clk);
    check_eq("abort_resp_state", 32'(dbg_state), 2);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    reset = 1'b0;
    cpu_req = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    txn(1'b1, 1'b0, 4'd2, 4'h0, 3);

    repeat (6) @(negedge clk);
    check_eq("cpu_q_drained", 32'(exp_cpu_q.size()), 0);
    check_eq("io_q_drained", 32'(exp_io_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
